// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types.
//   word_t       32-bit data/address word
//   ramstate_t   RAM status reported back to the arbiter
//   arb_state_t  RAM arbiter FSM states
//   ADDRINC_DEF  default byte step between the two words of a burst
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, W1, W2} arb_state_t;

  localparam int ADDRINC_DEF = 4;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req     per-requester request vector
//   rr_ptr  index searched first; search wraps upward modulo NREQ
//   pick    one-hot winner (0 when nothing requested)
//   valid   1 when any request is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port among NREQ requesters.
//   CLK, RST           clock, synchronous active-high reset
//   req/wen/burst      per-requester request, write, 2-word burst
//   addr/store         per-requester word address / write data
//   rwait/load         per-requester wait (0 on word completion) / read data
//   err                pulses for the cycle a transfer aborts on RAM ERROR
//   gnt                one-hot grant, 0 when idle
//   ramREN/ramWEN      RAM enables; ramaddr/ramstore address and write data
//   ramload/ramstate   RAM read data and status
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDRINC = ADDRINC_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wen,
  input  logic [NREQ-1:0]      burst,
  input  logic [NREQ-1:0][31:0] addr,
  input  logic [NREQ-1:0][31:0] store,
  output logic [NREQ-1:0]      rwait,
  output logic [NREQ-1:0][31:0] load,
  output logic                 err,
  output logic [NREQ-1:0]      gnt,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] g_q, g_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt, gidx, rr_after;
  logic [NREQ-1:0] pick;
  logic            pick_vld;

  logic        cur_req, cur_wen, cur_burst;
  logic [31:0] cur_addr, cur_store;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .valid  (pick_vld)
  );

  // Binary index of the registered one-hot grant.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (g_q[i]) gidx = PW'(i);
  end

  assign rr_after  = (int'(gidx) == NREQ-1) ? '0 : gidx + PW'(1);
  assign cur_req   = req[gidx];
  assign cur_wen   = wen[gidx];
  assign cur_burst = burst[gidx];
  assign cur_addr  = addr[gidx];
  assign cur_store = store[gidx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      g_q    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      g_q    <= g_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g_q;
    rr_nxt    = rr_ptr;
    rwait     = '1;
    load      = '0;
    err       = 1'b0;
    gnt       = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          g_nxt     = pick;
          state_nxt = W1;
        end
      end
      W1, W2: begin
        gnt         = g_q;
        ramaddr     = (state == W2) ? cur_addr + 32'(ADDRINC) : cur_addr;
        ramstore    = cur_store;
        ramWEN      = cur_wen;
        ramREN      = ~cur_wen;
        load[gidx]  = ramload;
        rwait[gidx] = (ramstate != ACCESS);
        // Completion, drop and error all leave through the same exit:
        // back to IDLE with the pointer moved past the current owner.
        if (!cur_req || ramstate == ERROR ||
            (ramstate == ACCESS && (state == W2 || !cur_burst))) begin
          err       = cur_req && (ramstate == ERROR);
          state_nxt = IDLE;
          g_nxt     = '0;
          rr_nxt    = rr_after;
        end else if (ramstate == ACCESS) begin
          state_nxt = W2;
        end
      end
      default: begin
        state_nxt = IDLE;
        g_nxt     = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic [3:0]       req, wen, burst;
  logic [3:0][31:0] addr, store;
  logic [3:0]       rwait;
  logic [3:0][31:0] load;
  logic             err;
  logic [3:0]       gnt;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  ram_arbiter #(.NREQ(4), .ADDRINC(4)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wen(wen), .burst(burst),
    .addr(addr), .store(store), .rwait(rwait), .load(load), .err(err),
    .gnt(gnt), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: who owns the RAM (-1 none), which word of the
  // transfer is on the bus, and where the next search begins.
  int m_g = -1;
  int m_word = 0;
  int m_ptr = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg, input logic [3:0] er,
                            input logic ee, input logic ern, input logic ewn,
                            input logic [31:0] ea, input logic [31:0] es,
                            input logic [127:0] el);
    chk({tag, ".gnt"},   128'(gnt), 128'(eg));
    chk({tag, ".rwait"}, 128'(rwait), 128'(er));
    chk({tag, ".err"},   128'(err), 128'(ee));
    chk({tag, ".ren"},   128'(ramREN), 128'(ern));
    chk({tag, ".wen"},   128'(ramWEN), 128'(ewn));
    chk({tag, ".addr"},  128'(ramaddr), 128'(ea));
    chk({tag, ".store"}, 128'(ramstore), 128'(es));
    chk({tag, ".load"},  128'(load), el);
  endtask

  task automatic check_idle(input string tag);
    check_outs(tag, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
  endtask

  task automatic model_update();
    bit done;
    if (RST) begin
      m_g = -1; m_ptr = 0; m_word = 0;
    end else if (m_g < 0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (m_g < 0 && req[j]) begin m_g = j; m_word = 0; end
      end
    end else begin
      done = !req[m_g] || ramstate == ERROR ||
             (ramstate == ACCESS && (m_word == 1 || !burst[m_g]));
      if (done) begin m_ptr = (m_g + 1) % 4; m_g = -1; end
      else if (ramstate == ACCESS) m_word = 1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic check_model();
    logic [3:0] eg, er;
    logic ee, ern, ewn;
    logic [31:0] ea, es;
    logic [3:0][31:0] el;
    eg = '0; er = 4'hF; ee = 0; ern = 0; ewn = 0; ea = '0; es = '0; el = '0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      ea      = addr[m_g] + 32'(4 * m_word);
      es      = store[m_g];
      ewn     = wen[m_g];
      ern     = !wen[m_g];
      el[m_g] = ramload;
      er[m_g] = (ramstate != ACCESS);
      ee      = req[m_g] && ramstate == ERROR;
    end
    check_outs("rand", eg, er, ee, ern, ewn, ea, es, el);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    ramstate_t   rs;
    logic [3:0]  e_gnt, e_rwait;
    logic        e_err, e_ren;
    logic [31:0] e_addr;
    int          e_li;
    logic        chk;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] rq, ramstate_t rs, logic [3:0] eg,
                              logic [3:0] er, logic ee, logic ern, logic [31:0] ea,
                              int li, logic c);
    vec_t v;
    v.rst = rst; v.rq = rq; v.rs = rs; v.e_gnt = eg; v.e_rwait = er;
    v.e_err = ee; v.e_ren = ern; v.e_addr = ea; v.e_li = li; v.chk = c;
    return v;
  endfunction

  vec_t tv[16];

  initial begin
    logic [3:0][31:0] el;
    logic [31:0] es;

    RST = 1'b1; req = '0; wen = '0; burst = '0; ramstate = FREE; ramload = 32'h0000_CAFE;
    addr[0] = 32'h40; addr[1] = 32'h100; addr[2] = 32'h300; addr[3] = 32'h200;
    for (int i = 0; i < 4; i++) store[i] = 32'h5000 + 32'(i);

    // Single read, error abort, pointer check after error, drop in W1.
    tv[0]  = mk(1, 4'h0, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 0);
    tv[1]  = mk(0, 4'h0, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[2]  = mk(0, 4'h2, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[3]  = mk(0, 4'h2, BUSY,   4'h2, 4'hF, 0, 1, 32'h100,  1, 1);
    tv[4]  = mk(0, 4'h2, BUSY,   4'h2, 4'hF, 0, 1, 32'h100,  1, 1);
    tv[5]  = mk(0, 4'h2, ACCESS, 4'h2, 4'hD, 0, 1, 32'h100,  1, 1);
    tv[6]  = mk(0, 4'h0, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[7]  = mk(0, 4'h4, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[8]  = mk(0, 4'h4, ERROR,  4'h4, 4'hF, 1, 1, 32'h300,  2, 1);
    tv[9]  = mk(0, 4'h0, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[10] = mk(0, 4'hC, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[11] = mk(0, 4'hC, ACCESS, 4'h8, 4'h7, 0, 1, 32'h200,  3, 1);
    tv[12] = mk(0, 4'h1, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);
    tv[13] = mk(0, 4'h1, BUSY,   4'h1, 4'hF, 0, 1, 32'h40,   0, 1);
    tv[14] = mk(0, 4'h0, BUSY,   4'h1, 4'hF, 0, 1, 32'h40,   0, 1);
    tv[15] = mk(0, 4'h0, FREE,   4'h0, 4'hF, 0, 0, 32'h0,   -1, 1);

    @(negedge CLK);
    foreach (tv[n]) begin
      RST = tv[n].rst; req = tv[n].rq; ramstate = tv[n].rs;
      #1;
      if (tv[n].chk) begin
        el = '0; es = '0;
        if (tv[n].e_li >= 0) begin
          el[tv[n].e_li] = ramload;
          es = 32'h5000 + 32'(tv[n].e_li);
        end
        check_outs($sformatf("vec%0d", n), tv[n].e_gnt, tv[n].e_rwait, tv[n].e_err,
                   tv[n].e_ren, 1'b0, tv[n].e_addr, es, el);
      end
      tick();
    end

    // Burst write on requester 3: two words, 0x200 then 0x204.
    RST = 1'b1; req = '0; tick();
    RST = 1'b0; req = 4'h8; wen = 4'h8; burst = 4'h8; ramstate = ACCESS;
    store[3] = 32'hDEAD_0003;
    #1 check_idle("bw.c0"); tick();
    el = '0; el[3] = ramload;
    #1 check_outs("bw.c1", 4'h8, 4'h7, 0, 0, 1, 32'h200, 32'hDEAD_0003, el); tick();
    #1 check_outs("bw.c2", 4'h8, 4'h7, 0, 0, 1, 32'h204, 32'hDEAD_0003, el); tick();
    #1 check_idle("bw.c3");
    req = '0; tick();

    // Fairness: all held, every grant single-cycle, idle gap between grants.
    RST = 1'b1; tick();
    RST = 1'b0; req = 4'hF; wen = '0; burst = '0; ramstate = ACCESS;
    for (int c = 0; c < 10; c++) begin
      logic [3:0] eg;
      eg = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'h0;
      #1 chk($sformatf("fair.c%0d.gnt", c), 128'(gnt), 128'(eg));
      tick();
    end

    // Reset in W2 kills the burst; arbitration restarts at requester 0.
    req = '0; RST = 1'b1; tick();
    RST = 1'b0; req = 4'h8; wen = 4'h8; burst = 4'h8; ramstate = ACCESS;
    tick(); tick();
    #1 chk("rst.w2.addr", 128'(ramaddr), 128'(32'h204));
    RST = 1'b1; tick();
    RST = 1'b0; req = 4'hF; burst = '0;
    #1 check_idle("rst.after"); tick();
    #1 chk("rst.regnt", 128'(gnt), 128'(4'h1)); tick();

    // Randomized run against the reference model.
    req = '0; RST = 1'b1; tick();
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 99) == 0);
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload = $urandom;
      for (int i = 0; i < 4; i++) begin
        if (m_g == i) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else begin
          req[i]   = 1'($urandom_range(0, 1));
          wen[i]   = 1'($urandom_range(0, 1));
          burst[i] = 1'($urandom_range(0, 1));
          addr[i]  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 3)) << 2;
        end
        store[i] = $urandom;
      end
      #1 check_model();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (0: core0 I, 1: core0 D, 2: core1 I, 3: core1 D).
REQ-002 SHALL have parameter ADDRINC, default 4, byte increment between burst words.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester access request, held until the transaction completes.
REQ-006 wen  input  NREQ  per-requester write (1) or read (0).
REQ-007 burst  input  NREQ  per-requester 2-word block transfer (1) or single word (0).
REQ-008 addr  input  NREQ x 32  per-requester word address; base address for a burst.
REQ-009 store  input  NREQ x 32  per-requester write data for the current word.
REQ-010 rwait  output  NREQ  per-requester wait; 0 only in the cycle its word completes.
REQ-011 load  output  NREQ x 32  per-requester read data.
REQ-012 err  output  1  one-cycle pulse when a transaction aborts on RAM ERROR.
REQ-013 gnt  output  NREQ  one-hot current grant, 0 when idle.
REQ-014 ramREN, ramWEN  output  1 each  RAM read/write enables.
REQ-015 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 ramload  input  32  RAM read data.
REQ-017 ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-018 SHALL implement states IDLE, W1, W2.
REQ-019 IDLE: if any req set, SHALL register grant g = first set req searching upward from rr_ptr modulo NREQ, and go to W1; otherwise SHALL stay in IDLE.
REQ-020 Arbitration latency SHALL be exactly one cycle: req seen in IDLE at cycle N means RAM is driven from cycle N+1.
REQ-021 W1/W2: ramaddr SHALL be addr[g] in W1 and addr[g]+ADDRINC in W2 (32-bit wrap).
REQ-022 W1/W2: ramstore SHALL be store[g], ramWEN SHALL be wen[g], and ramREN SHALL be ~wen[g].
REQ-023 W1/W2: load[g] SHALL equal ramload; rwait[g] SHALL be 0 iff ramstate==ACCESS.
REQ-024 W1 on ACCESS: SHALL go to W2 if burst[g], else complete.
REQ-025 W2 on ACCESS: SHALL complete.
REQ-026 FREE or BUSY in W1/W2 SHALL hold the state with all outputs unchanged.
REQ-027 Completion SHALL set rr_ptr to (g+1) mod NREQ and return to IDLE, so there are no back-to-back grants without an IDLE cycle.
REQ-028 req[g] deasserted in W1/W2 SHALL abort to IDLE next cycle, with rr_ptr advanced as on completion and no err.
REQ-029 ramstate==ERROR in W1/W2 SHALL pulse err for that cycle, keep rwait[g] high, and abort as in REQ-028.
REQ-030 Outside a grant, every rwait bit SHALL be 1, load SHALL be 0, ramREN=ramWEN=0, ramaddr=ramstore=0, and gnt=0.
REQ-031 Non-granted requesters SHALL never see rwait=0, including when their addr equals addr[g].
REQ-032 burst, wen and addr[g] SHALL be sampled combinationally each cycle; requesters SHALL hold them stable during a grant.

Reset
REQ-033 RST high at a clock edge SHALL force state IDLE, rr_ptr=0, grant cleared and err=0, overriding any in-progress transfer.
REQ-034 In the cycle after reset, all outputs SHALL take the REQ-030 idle values.
REQ-035 A transfer interrupted by reset SHALL NOT be resumed; the requester re-arbitrates.

Structure
REQ-036 ramstate_t and word_t SHALL come from cpu_types_pkg.
REQ-037 The arb_state_t enum (IDLE, W1, W2) and ADDRINC default SHALL be added to cpu_types_pkg.
REQ-038 SHALL contain one sub-module, rr_pick: combinational round-robin priority encoder taking req and rr_ptr and returning a one-hot pick plus a valid flag.

Verification
REQ-039 Single read: req[1]=1, wen=0, burst=0, addr=0x100, ACCESS after 2 BUSY cycles, ramload=0xCAFE -> ramREN=1 and ramaddr=0x100 from cycle 1; rwait[1]=0 and load[1]=0xCAFE in cycle 3; IDLE in cycle 4.
REQ-040 Burst write: req[3]=1, wen=1, burst=1, addr=0x200, ramstate always ACCESS -> ramaddr 0x200 then 0x204 on consecutive cycles, with two rwait[3]=0 pulses.
REQ-041 Fairness: all four req held, ramstate always ACCESS -> grant order 0,1,2,3,0 and no requester waits for more than 3 other grants.
REQ-042 Error: grant on req[2] with ramstate=ERROR -> one-cycle err pulse, rwait[2] stays 1, IDLE next cycle, rr_ptr=3.
REQ-043 Reset mid-burst: RST asserted in W2 -> next cycle gnt=0, ramWEN=ramREN=0, and the next grant starts from requester 0.
REQ-044 Drop: req[0] deasserted in W1 while BUSY -> IDLE next cycle, err=0, and no rwait pulse.
